// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluc,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div0
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic [3:0]       op;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] hi, lo, hi_n, lo_n;
    logic [SHW:0]     cnt;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum, dif, fast_res;
    logic             fast_ovf;
    logic             iter_op, div_by_zero;
    logic [WIDTH:0]   madd, dshift, dtrial;
    logic [WIDTH-1:0] fin;

    assign shamt       = src2[SHW-1:0];
    assign sum         = src1 + src2;
    assign dif         = src1 - src2;
    assign iter_op     = (aluc[3:2] == 2'b10);
    assign div_by_zero = aluc[1] && (src2 == '0);
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);

    always_comb begin
        fast_res = '0;
        fast_ovf = 1'b0;
        case (aluc)
            4'd0:  fast_res = src1 & src2;
            4'd1:  fast_res = src1 | src2;
            4'd2: begin
                fast_res = sum;
                fast_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            4'd3:  fast_res = src1 >> shamt;
            4'd4:  fast_res = src1 ^ src2;
            4'd5:  fast_res = src1 << shamt;
            4'd6: begin
                fast_res = dif;
                fast_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (dif[WIDTH-1] != src1[WIDTH-1]);
            end
            4'd7:  fast_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            4'd12: fast_res = $unsigned($signed(src1) >>> shamt);
            4'd13: fast_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            default: fast_res = '0;
        endcase
    end

    // One radix-2 step: multiply keeps {hi,lo} as partial product / multiplier,
    // divide keeps hi as remainder and shifts quotient bits into lo.
    always_comb begin
        madd   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        dshift = {hi, lo[WIDTH-1]};
        dtrial = dshift - {1'b0, opb};
        if (op[1]) begin
            hi_n = dtrial[WIDTH] ? dshift[WIDTH-1:0] : dtrial[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ~dtrial[WIDTH]};
        end else begin
            hi_n = madd[WIDTH:1];
            lo_n = {madd[0], lo[WIDTH-1:1]};
        end
        fin = op[0] ? hi_n : lo_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = (iter_op && !div_by_zero) ? BUSY : DONE;
            BUSY: if (cnt == (SHW+1)'(1)) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op  <= aluc;
                    opb <= src2;
                    if (iter_op && div_by_zero) begin
                        result <= aluc[0] ? src1 : '1;
                        zero   <= aluc[0] ? (src1 == '0) : 1'b0;
                        ovf    <= 1'b0;
                        div0   <= 1'b1;
                    end else if (iter_op) begin
                        hi  <= '0;
                        lo  <= src1;
                        cnt <= (SHW+1)'(WIDTH);
                    end else begin
                        result <= fast_res;
                        zero   <= (fast_res == '0);
                        ovf    <= fast_ovf;
                        div0   <= 1'b0;
                    end
                end
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - (SHW+1)'(1);
                    if (cnt == (SHW+1)'(1)) begin
                        result <= fin;
                        zero   <= (fin == '0);
                        ovf    <= 1'b0;
                        div0   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops checked
// against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  aluc = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero, ovf, div0;

    int errors = 0;
    int checks = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluc(aluc), .src1(src1), .src2(src2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode meanings.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic d0,
                                  output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = 64'(a) * 64'(b);
        r   = '0;
        ov  = 1'b0;
        d0  = 1'b0;
        lat = 1;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin s = sa + sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3:  r = a >> b[4:0];
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6: begin s = sa - sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8: begin r = p[31:0];  lat = 33; end
            4'd9: begin r = p[63:32]; lat = 33; end
            4'd10: if (b == 0) begin r = 32'hFFFF_FFFF; d0 = 1'b1; end else begin r = a / b; lat = 33; end
            4'd11: if (b == 0) begin r = a; d0 = 1'b1; end else begin r = a % b; lat = 33; end
            4'd12: r = $unsigned($signed(a) >>> b[4:0]);
            4'd13: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, input string tag);
        logic [31:0] er;
        logic        eo, ed;
        int          el, lat;
        model(op, a, b, er, eo, ed, el);
        aluc = op; src1 = a; src2 = b; in_valid = 1'b1;
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        aluc = 4'($urandom); src1 = $urandom; src2 = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(el));
        checkOutput({tag, ".result"}, 64'(result), 64'(er));
        checkOutput({tag, ".zero"}, 64'(zero), 64'(er == 32'd0));
        checkOutput({tag, ".ovf"}, 64'(ovf), 64'(eo));
        checkOutput({tag, ".div0"}, 64'(div0), 64'(ed));
        checkOutput({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            src1 = $urandom; src2 = $urandom;
            @(posedge clk); #1;
            checkOutput({tag, ".hold_result"}, 64'(result), 64'(er));
            checkOutput({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput({tag, ".handoff_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ".handoff_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        #1;
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
        checkOutput("reset.flags", 64'({zero, ovf, div0}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);

        applyStimulus(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");

        aluc = 4'd8; src1 = $urandom; src2 = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mul.out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mul.result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_mul.in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_mul.no_output", 64'(out_valid), 64'd0);

        applyStimulus(4'd6,  32'd5,          32'd5,          1, "sub_zero");
        applyStimulus(4'd13, 32'hFFFF_FFFF,  32'd1,          0, "slt");
        applyStimulus(4'd7,  32'hFFFF_FFFF,  32'd1,          0, "sltu");
        applyStimulus(4'd8,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, "mul");
        applyStimulus(4'd9,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, "mulhu");
        applyStimulus(4'd10, 32'd100,        32'd7,          0, "divu");
        applyStimulus(4'd11, 32'd100,        32'd7,          0, "remu");
        applyStimulus(4'd10, 32'd9,          32'd0,          0, "divu0");
        applyStimulus(4'd11, 32'd9,          32'd0,          0, "remu0");
        applyStimulus(4'd12, 32'h8000_0000,  32'h0000_0021,  4, "sra_hold");
        applyStimulus(4'd6,  32'h8000_0000,  32'd1,          0, "sub_ovf");
        applyStimulus(4'd15, 32'h1234_5678,  32'h9ABC_DEF0,  0, "op15");

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            applyStimulus(rop, ra, rb, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", n, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
